// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the pulse/reply handshake.
// A read or write request is a one-cycle pulse. It is served from an internal
// word array, and the reply pulse arrives a fixed LATENCY cycles after the request.
// Optional feature macro: MEM_PROT_CHECK_EN adds the sticky prot_err output.
//
// state   | meaning
// S_IDLE  | no request in flight; accepts a new request
// S_WAIT  | request latched; latency counter running; busy=1
// S_REPLY | mem_reply high this cycle; can accept a back-to-back request
module mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 31,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_pulse,
  input  logic              mem_write_pulse,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_reply,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef MEM_PROT_CHECK_EN
  ,
  output logic              prot_err
`endif
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_range
    $error("mem_responder: LATENCY must be in 1..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REPLY} state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic                op_write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   mem [2**ADDR_W];

  logic                req_one;
  logic                accept;
  logic                from_wait;
  logic                go_reply;
  logic                acc_write;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;

  // Request qualification and the access to apply on the edge entering S_REPLY.
  // With LATENCY=1 the access comes straight from the request inputs.
  always_comb begin
    req_one   = mem_read_pulse ^ mem_write_pulse;
    accept    = (state == S_IDLE || state == S_REPLY) && req_one;
    from_wait = (state == S_WAIT) && (cnt == 4'd1);
    go_reply  = from_wait || (accept && LATENCY == 1);
    if (from_wait) begin
      acc_write = op_write_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end else begin
      acc_write = mem_write_pulse;
      acc_addr  = mem_addr;
      acc_wdata = mem_wdata;
    end
  end

  // Control FSM with registered reply, read data and busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_reply  <= 1'b0;
      mem_rdata  <= '0;
      busy       <= 1'b0;
    end else begin
      mem_reply <= go_reply;
      if (go_reply && !acc_write) mem_rdata <= mem[acc_addr];
      case (state)
        S_IDLE, S_REPLY: begin
          if (accept) begin
            op_write_q <= mem_write_pulse;
            addr_q     <= mem_addr;
            wdata_q    <= mem_wdata;
            cnt        <= 4'(LATENCY - 1);
            if (LATENCY == 1) begin
              state <= S_REPLY;
              busy  <= 1'b0;
            end else begin
              state <= S_WAIT;
              busy  <= 1'b1;
            end
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= S_REPLY;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Word array, not reset. A write lands on the same edge that raises mem_reply.
  always_ff @(posedge clk) begin
    if (go_reply && acc_write && !reset) mem[acc_addr] <= acc_wdata;
  end

`ifdef MEM_PROT_CHECK_EN
  // Sticky flag: a pulse while busy, or read and write pulses raised together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prot_err <= 1'b0;
    end else if ((state == S_WAIT && (mem_read_pulse || mem_write_pulse)) ||
                 (mem_read_pulse && mem_write_pulse)) begin
      prot_err <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the pulse/reply handshake driven by pulse_unit.
- Accepts one-cycle mem_read_pulse / mem_write_pulse requests and services them against an internal word array.
- Answers each accepted request with exactly one one-cycle mem_reply after a fixed LATENCY.
- Replaces the behavioural memory model with synthesizable RTL.

Parameters:
- ADDR_W, 10, word address width; array depth = 2**ADDR_W.
- DATA_W, 31, word width.
- LATENCY, 2, cycles from request pulse to mem_reply; legal range 1..15.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_read_pulse  input  1  one-cycle read request.
- mem_write_pulse  input  1  one-cycle write request.
- mem_addr  input  ADDR_W  word address, sampled in the request cycle.
- mem_wdata  input  DATA_W  write data, sampled in the request cycle.
- mem_reply  output  1  one-cycle completion pulse.
- mem_rdata  output  DATA_W  read data, valid from the mem_reply cycle.
- busy  output  1  request in flight.
- prot_err  output  1  sticky protocol error; present only with MEM_PROT_CHECK_EN.

Behaviour:
- Reset (asynchronous, active-high):
  - mem_reply=0, mem_rdata=0, busy=0, prot_err=0; FSM to IDLE; counter=0.
  - Array contents are not reset.
  - Reset mid-operation aborts the request: no reply is issued and a pending write is not committed.
- FSM states:
  - IDLE: exactly one of read/write pulse high in cycle t -> latch op, addr, wdata; counter=LATENCY-1; busy=1 from cycle t+1; go to WAIT (or straight to REPLY if LATENCY=1).
  - WAIT: counter decrements each cycle; at 0 go to REPLY.
  - REPLY: mem_reply=1 for exactly cycle t+LATENCY.
    - Write: array[addr] <= wdata at the edge entering REPLY.
    - Read: mem_rdata <= array[addr] at the same edge.
    - busy=0 in this cycle.
    - Next state is IDLE, or re-accept directly (see back-to-back).
- Back-to-back: a request pulse in the REPLY cycle is accepted; its reply lands LATENCY cycles later. Minimum spacing between replies is LATENCY cycles.
- mem_rdata holds its value until the next read reply; write replies leave it unchanged.
- Read after write to the same address returns the newly written data, since the write is committed before the later request samples the array.
- Request pulse while busy=1 (WAIT, or REPLY-1 cycles): ignored; no second reply; the in-flight op is unaffected.
- mem_read_pulse and mem_write_pulse high in the same cycle: request ignored, no reply, no array change.
- Pulse held high for more than one cycle counts as one request at its first cycle; later cycles fall under the busy-ignore rule.
- Counter width 4 bits; LATENCY outside 1..15 is a compile-time error (generate-time check).

Optional Feature:
- Macro: MEM_PROT_CHECK_EN.
- Defined:
  - prot_err port exists.
  - Set (sticky until reset) when a pulse arrives while busy=1, or when read and write pulses are high together.
  - Set on the edge after the offending cycle.
  - Requests are still ignored as above.
- Undefined:
  - prot_err port and its logic are absent.
  - The same violations are silently ignored with identical reply/array behaviour.

Test Plan:
- Write then read: write pulse addr=0x012 data=0x1234567 at cycle 10 -> mem_reply only at cycle 12. Read pulse addr=0x012 at cycle 14 -> mem_reply at cycle 16 with mem_rdata=0x1234567.
- Back-to-back: write addr 5 data 0x55 at t; write addr 6 data 0x66 in reply cycle t+2; read 5 at t+4; read 6 at t+6 -> four replies at t+2, t+4, t+6, t+8; rdata 0x55 then 0x66.
- Overlap: read pulse at t, second read pulse at t+1 -> single reply at t+2. With MEM_PROT_CHECK_EN, prot_err=1 from t+2 and stays 1.
- Simultaneous read+write pulse -> no reply within 20 cycles; array word unchanged on later read; prot_err=1 if macro enabled.
- Reset mid-op: write addr 3 data 0x7 at t, reset high at t+1 -> no reply; mem_reply=0, busy=0. After release, read addr 3 returns the prior contents, not 0x7.
- LATENCY=1 build: read pulse at t -> mem_reply at t+1; read pulses every cycle -> a reply every cycle, with rdata tracking addresses in order.
